// File: rtl/aes_arb_pkg.sv
// Shared types and defaults for the AES request arbiter.
package aes_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DELIVER   = 3'd4
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/aes_req_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after last_grant+1, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  pick,
  output logic             any_valid
);

  logic [ID_W-1:0]    start;
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;
  logic               found;
  int unsigned        idx;

  // Rotate the doubled request vector so bit 0 is last_grant+1, then take the lowest set bit.
  always_comb begin
    start     = (last_grant >= ID_W'(N_REQ - 1)) ? '0 : last_grant + ID_W'(1);
    dbl       = {req_valid, req_valid};
    shifted   = dbl >> start;
    rot       = shifted[N_REQ-1:0];
    any_valid = |req_valid;
    found     = 1'b0;
    idx       = 0;
    pick      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = 32'(start) + i;
        if (idx >= N_REQ) begin
          idx = idx - N_REQ;
        end
        pick = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between N_REQ plaintext sources; one block in flight,
// round-robin grant, tagged response, hung-core timeout.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  localparam int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*BLOCK_W-1:0] req_pt,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     aes_ready,
  output logic                     aes_start,
  output logic [BLOCK_W-1:0]       pt_to_aes,
  input  logic [BLOCK_W-1:0]       ct_from_aes,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BLOCK_W-1:0]       rsp_ct,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     err,
  output logic [ID_W-1:0]          err_id,
  output logic                     busy
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ID_W-1:0]    pick;
  logic               any_valid;

  logic [N_REQ-1:0]   req_ready_d;
  logic               aes_start_d;
  logic [BLOCK_W-1:0] pt_d;
  logic               rsp_valid_d;
  logic [BLOCK_W-1:0] rsp_ct_d;
  logic [ID_W-1:0]    rsp_id_d;
  logic               err_d;
  logic [ID_W-1:0]    err_id_d;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any_valid  (any_valid)
  );

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    req_ready_d  = '0;
    aes_start_d  = 1'b0;
    pt_d         = pt_to_aes;
    rsp_valid_d  = rsp_valid;
    rsp_ct_d     = rsp_ct;
    rsp_id_d     = rsp_id;
    err_d        = 1'b0;
    err_id_d     = err_id;
    unique case (state_q)
      IDLE: begin
        if (any_valid && aes_ready) begin
          pt_d              = req_pt[pick*BLOCK_W +: BLOCK_W];
          grant_d           = pick;
          req_ready_d[pick] = 1'b1;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        aes_start_d = 1'b1;
        timer_d     = '0;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // aes_ready may still be high from the previous block; wait for it to drop first.
        if (!aes_ready) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          err_d        = 1'b1;
          err_id_d     = grant_q;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (aes_ready) begin
          rsp_ct_d    = ct_from_aes;
          rsp_id_d    = grant_q;
          rsp_valid_d = 1'b1;
          state_d     = DELIVER;
        end else if (timer_q == TMR_LAST) begin
          err_d        = 1'b1;
          err_id_d     = grant_q;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DELIVER: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bookkeeping and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      timer_q      <= '0;
      req_ready    <= '0;
      aes_start    <= 1'b0;
      pt_to_aes    <= '0;
      rsp_valid    <= 1'b0;
      rsp_ct       <= '0;
      rsp_id       <= '0;
      err          <= 1'b0;
      err_id       <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      req_ready    <= req_ready_d;
      aes_start    <= aes_start_d;
      pt_to_aes    <= pt_d;
      rsp_valid    <= rsp_valid_d;
      rsp_ct       <= rsp_ct_d;
      rsp_id       <= rsp_id_d;
      err          <= err_d;
      err_id       <= err_id_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a behavioural AES core model.
`timescale 1ns/1ps
module tb_aes_req_arbiter;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [127:0] VEC_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic [0:0]   id;
    logic [127:0] ct;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*BLOCK_W-1:0] req_pt;
  logic [N_REQ-1:0]         req_ready;
  logic                     aes_ready;
  logic                     aes_start;
  logic [BLOCK_W-1:0]       pt_to_aes;
  logic [BLOCK_W-1:0]       ct_from_aes;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [BLOCK_W-1:0]       rsp_ct;
  logic [0:0]               rsp_id;
  logic                     err;
  logic [0:0]               err_id;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_cnt = 0, st_cnt = 0, rsp_cnt = 0, err_cnt = 0;
  int gr_cyc = 0, st_cyc = 0, err_cyc = 0, last_err_id = 0;
  int mode = 0;      // 0 normal, 1 never drops aes_ready, 2 drops and never raises
  int latency = 10;
  int model_rst_req = 0;

  exp_t         exp_q[$];
  logic [127:0] q0[$];
  logic [127:0] q1[$];
  int           grant_log[$];

  aes_req_arbiter #(
    .N_REQ   (N_REQ),
    .BLOCK_W (BLOCK_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_pt      (req_pt),
    .req_ready   (req_ready),
    .aes_ready   (aes_ready),
    .aes_start   (aes_start),
    .pt_to_aes   (pt_to_aes),
    .ct_from_aes (ct_from_aes),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_ct      (rsp_ct),
    .rsp_id      (rsp_id),
    .err         (err),
    .err_id      (err_id),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [127:0] aes_fn(input logic [127:0] pt);
    if (pt == VEC_PT) return VEC_CT;
    return {pt[63:0], pt[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_f0f0_3c3c_c3c3;
  endfunction

  task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_i(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name, input int max);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within %0d cycles, required it", name, max);
  endtask

  task automatic push_exp(input logic [0:0] id, input logic [127:0] pt);
    exp_t e;
    e.id = id;
    e.ct = aes_fn(pt);
    exp_q.push_back(e);
  endtask

  // AES core model: drops aes_ready the cycle after aes_start, raises it with ct after latency.
  initial begin
    int  cnt = 0;
    int  seen_rst = 0;
    bit  pending = 0;
    logic [127:0] pt_hold = '0;
    aes_ready   = 1'b1;
    ct_from_aes = '0;
    forever begin
      @(posedge clk); #1;
      if (model_rst_req != seen_rst) begin
        seen_rst  = model_rst_req;
        aes_ready = 1'b1;
        pending   = 0;
        cnt       = 0;
      end else if (pending) begin
        pending = 0;
        if (mode != 1) begin
          aes_ready = 1'b0;
          cnt       = latency;
        end
      end else if (!aes_ready && mode != 2) begin
        if (cnt <= 1) begin
          aes_ready   = 1'b1;
          ct_from_aes = aes_fn(pt_hold);
          cnt         = 0;
        end else begin
          cnt--;
        end
      end
      if (aes_start) begin
        pending = 1;
        pt_hold = pt_to_aes;
      end
    end
  end

  // Requesters: present queue head, pop on the req_ready pulse.
  initial begin
    req_valid = '0;
    req_pt    = '0;
    forever begin
      @(posedge clk); #1;
      if (req_ready[0] && q0.size() > 0) void'(q0.pop_front());
      if (req_ready[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0]       = (q0.size() > 0);
      req_valid[1]       = (q1.size() > 0);
      req_pt[0 +: 128]   = (q0.size() > 0) ? q0[0] : '0;
      req_pt[128 +: 128] = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Monitor: logs pulses and pops the scoreboard on each response handshake.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (req_ready != '0) begin
        rr_cnt++;
        gr_cyc = cyc;
        grant_log.push_back(req_ready[1] ? 1 : 0);
        check_i("grant_onehot", int'($onehot(req_ready)), 1);
      end
      if (aes_start) begin
        st_cnt++;
        st_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        err_cyc     = cyc;
        last_err_id = int'(err_id);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d ct %h, required no response", rsp_id, rsp_ct);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_i("rsp_id", int'(rsp_id), int'(e.id));
          check_v("rsp_ct", rsp_ct, e.ct);
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy && !rsp_valid)
           && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) timeout_fail(name, max);
  endtask

  task automatic wait_err(input string name, input int base, input int max);
    int n = 0;
    while (err_cnt == base && n < max) begin
      @(negedge clk);
      n++;
    end
    if (err_cnt == base) timeout_fail(name, max);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    model_rst_req++;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int b_rr, b_st, b_rsp, b_err, rr_mid, unstable, n;
    logic [127:0] ct0;
    logic [0:0]   id0;
    int exp_grants[6] = '{0, 1, 0, 1, 0, 1};

    reset     = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_i("reset_ctl", int'({req_ready, aes_start, rsp_valid, rsp_id, err, err_id, busy}), 0);
    check_v("reset_pt", pt_to_aes, '0);
    check_v("reset_ct", rsp_ct, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: single request with the known vector
    b_rr = rr_cnt; b_st = st_cnt; b_rsp = rsp_cnt;
    push_exp(1'b0, VEC_PT);
    q0.push_back(VEC_PT);
    wait_drain("t1_drain", 100);
    check_i("t1_req_ready_pulses", rr_cnt - b_rr, 1);
    check_i("t1_aes_start_pulses", st_cnt - b_st, 1);
    check_i("t1_start_latency", st_cyc - gr_cyc, 1);
    check_i("t1_rsp_count", rsp_cnt - b_rsp, 1);

    // 2: both requesters continuously valid after reset
    apply_reset();
    grant_log.delete();
    b_rsp = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(128'hA000 + 128'(i));
      q1.push_back(128'hB000 + 128'(i));
    end
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 128'hA000 + 128'(i));
      push_exp(1'b1, 128'hB000 + 128'(i));
    end
    wait_drain("t2_drain", 400);
    check_i("t2_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check_i($sformatf("t2_grant_%0d", i), grant_log[i], exp_grants[i]);
    check_i("t2_rsp_count", rsp_cnt - b_rsp, 6);

    // 3: 50 cycles of backpressure in DELIVER
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    b_rsp = rsp_cnt;
    push_exp(1'b0, 128'hC3C3);
    q0.push_back(128'hC3C3);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout_fail("t3_rsp_valid", 100);
    ct0 = rsp_ct;
    id0 = rsp_id;
    rr_mid = rr_cnt;
    q1.push_back(128'hD4D4);
    push_exp(1'b1, 128'hD4D4);
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rsp_valid || rsp_ct !== ct0 || rsp_id !== id0) unstable++;
    end
    check_i("t3_unstable_cycles", unstable, 0);
    check_i("t3_no_req_ready", rr_cnt - rr_mid, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_i("t3_idle_after", int'({busy, rsp_valid}), 0);
    check_i("t3_one_transfer", rsp_cnt - b_rsp, 1);
    wait_drain("t3_drain", 100);

    // 4: core never drops aes_ready -> abort in WAIT_BUSY
    mode = 1;
    b_rsp = rsp_cnt; b_err = err_cnt;
    q1.push_back(128'hE5E5);
    wait_err("t4_err", b_err, 100);
    check_i("t4_err_count", err_cnt - b_err, 1);
    check_i("t4_err_id", last_err_id, 1);
    check_i("t4_err_delay", err_cyc - st_cyc, TIMEOUT);
    check_i("t4_no_rsp", rsp_cnt - b_rsp, 0);
    mode = 0;
    push_exp(1'b0, 128'hF6F6);
    q0.push_back(128'hF6F6);
    wait_drain("t4_next_drain", 100);

    // 5: core drops aes_ready and never raises it -> abort in WAIT_DONE
    mode = 2;
    b_rsp = rsp_cnt; b_err = err_cnt;
    q0.push_back(128'h1717);
    wait_err("t5_err", b_err, 100);
    check_i("t5_err_id", last_err_id, 0);
    check_i("t5_err_delay", err_cyc - st_cyc, TIMEOUT + 2);
    check_i("t5_busy_at_err", int'(busy), 0);
    @(negedge clk);
    check_i("t5_busy_after", int'(busy), 0);
    check_i("t5_no_rsp", rsp_cnt - b_rsp, 0);
    mode = 0;

    // 6: reset pulse while in WAIT_DONE
    latency = 12;
    b_rsp = rsp_cnt; b_err = err_cnt; b_st = st_cnt;
    q1.push_back(128'h2828);
    n = 0;
    while (st_cnt == b_st && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (st_cnt == b_st) timeout_fail("t6_start", 100);
    repeat (4) @(negedge clk);
    check_i("t6_busy_before", int'(busy), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_rst_req++;
    @(posedge clk); #1;
    check_i("t6_reset_ctl", int'({req_ready, aes_start, rsp_valid, rsp_id, err, err_id, busy}), 0);
    check_v("t6_reset_pt", pt_to_aes, '0);
    check_v("t6_reset_ct", rsp_ct, '0);
    reset = 1'b1;
    latency = 10;
    grant_log.delete();
    q0.push_back(128'h3939);
    q1.push_back(128'h4A4A);
    push_exp(1'b0, 128'h3939);
    push_exp(1'b1, 128'h4A4A);
    wait_drain("t6_drain", 200);
    check_i("t6_grant_count", grant_log.size(), 2);
    if (grant_log.size() > 0) check_i("t6_first_grant", grant_log[0], 0);
    check_i("t6_rsp_count", rsp_cnt - b_rsp, 2);
    check_i("t6_no_err", err_cnt - b_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
